uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver; successor to the fixed 8N1 receiver.
- Generalised in data width, oversampling ratio, parity and stop-bit count.
- Adds input synchronisation, 3-sample majority voting, false-start rejection, a valid/ready output handshake and framing/parity/overrun error reporting.
- Sits between the shared baud-tick generator and downstream byte consumers (FIFO or register interface).

Parameters:
D_W, 8, data bits per frame; legal 5..9; LSB received first
B_TICK, 16, tick input pulses per bit period; even, >= 8
PARITY_EN, 0, 1 = parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-low reset (0 = reset)
tick  in  1  oversampling strobe, one clk wide, B_TICK per bit
rx_data  in  1  serial line, asynchronous to clk, idle high
out_data  out  D_W  received word
out_valid  out  1  out_data and error flags are valid
out_ready  in  1  consumer accepts the word when out_valid & out_ready
frame_err  out  1  stop bit(s) sampled low; qualified by out_valid
parity_err  out  1  parity mismatch; qualified by out_valid; always 0 if PARITY_EN=0
overrun_err  out  1  one-clk pulse: a completed frame was dropped
busy  out  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset (rst=0, immediate, asynchronous):
  - FSM to IDLE; tick counter, bit counter and shift register cleared.
  - out_data=0; out_valid, frame_err, parity_err, overrun_err and busy all 0.
  - Both synchroniser flops preset to 1 so no false start occurs on release.
  - Reset mid-frame aborts the frame silently.
- Input path: two-flop synchroniser; all FSM decisions use the synchronised value rxs.
- Tick counter tc runs 0..B_TICK-1 on tick pulses only; it wraps to 0 at each bit boundary.
- Bit value = majority of rxs captured at the ticks where tc = B_TICK/2-1, B_TICK/2 and B_TICK/2+1.
- FSM states and transitions:
  - IDLE: when rxs=0, go to START with tc=0. The edge-detect clk is tick-independent.
  - START: at tc=B_TICK/2+1, if the majority is 1, this is a false start: return to IDLE, no output, no error. Otherwise go to DATA when tc wraps.
  - DATA: D_W bits, shifted in LSB-first. The bit is decided at the tc=B_TICK-1 tick. After bit D_W-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: the voted bit is compared with the XOR of the data bits (inverted if PARITY_ODD); mismatch sets the pending parity error. Go to STOP at the tc=B_TICK-1 tick.
  - STOP:
    - STOP_BITS=2: the first stop bit occupies a full period, the second is decided at its middle.
    - The final stop bit is decided at tc=B_TICK/2+1; the FSM then completes the frame without waiting for the end of the bit (allows resync to the next start edge).
    - Any stop bit voting 0 sets the pending frame error.
    - Next state: IDLE if the last stop bit voted 1, else BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. No new start is detected while in BREAK.
- Frame completion (the clk edge of the final stop decision):
  - out_valid=0, or out_valid & out_ready this cycle: load out_data, frame_err and parity_err; out_valid=1 from the next cycle. Simultaneous accept and load yields no overrun.
  - out_valid=1 & out_ready=0: the new frame is discarded; out_data, flags and out_valid are unchanged; overrun_err pulses high for 1 clk.
- Handshake:
  - out_valid stays high until out_valid & out_ready at a posedge, which clears out_valid the following cycle. frame_err and parity_err clear with it.
  - out_data holds its value after acceptance until the next load.
- Latency: out_valid rises 1 clk after the tick that decides the last stop bit.
- Widths: bit counter is $clog2(D_W+1) bits and tc is $clog2(B_TICK) bits. No counter may overflow at legal parameter values.

Test Plan:
- Defaults, tick every clk (16 clk/bit), send 0xA5 8N1 with out_ready=1. Required: out_data=0xA5, out_valid for 1 clk, both error flags 0, busy returns to 0.
- Pull rx_data low for 5 clk, then return high. Required: busy rises then drops by tc=9, out_valid stays 0, no errors; a following 0x3C frame is received correctly.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1, then 0x07 with parity bit 0. Required: first parity_err=0, second parity_err=1 with out_data=0x07.
- Send 0x55 with the stop bit low and rx_data held low for 40 clk. Required: out_data=0x55, frame_err=1, FSM held in BREAK until rx_data=1, then the next 0x12 frame is received cleanly.
- Hold out_ready=0 and send 0x11 then 0x22. Required: out_data stays 0x11, overrun_err pulses 1 clk at the second completion; raising out_ready clears out_valid.
- Assert rst=0 mid-DATA of 0xF0 with no clk edge. Required: immediate out_valid=0 and busy=0; after release, a 0x81 frame is received correctly. Also send a single glitch sample inside a data bit and require the majority vote to reject it.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised oversampling UART receiver with 3-sample majority voting,
// false-start rejection, valid/ready output and framing/parity/overrun reporting.
module uart_rx_cfg #(
  parameter int D_W        = 8,
  parameter int B_TICK     = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           rx_data,
  output logic [D_W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           frame_err,
  output logic           parity_err,
  output logic           overrun_err,
  output logic           busy
);
  localparam int TW = $clog2(B_TICK);
  localparam int BW = $clog2(D_W + 1);
  localparam logic [TW-1:0] T_LO  = TW'(B_TICK / 2 - 1);
  localparam logic [TW-1:0] T_MID = TW'(B_TICK / 2);
  localparam logic [TW-1:0] T_HI  = TW'(B_TICK / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(B_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(D_W - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state, state_n;

  logic s1, rxs, bit_v, ferr_p, perr_p, maj, vote, bend, done, load;
  logic [1:0]     smp;
  logic [TW-1:0]  tc;
  logic [BW-1:0]  bc;
  logic [D_W-1:0] sh;

  // third sample is the live rxs at the deciding tick
  assign maj  = (smp[0] & smp[1]) | (rxs & (smp[0] | smp[1]));
  assign vote = tick && tc == T_HI;
  assign bend = tick && tc == T_END;
  assign load = done && (!out_valid || out_ready);
  assign busy = state != IDLE;

  always_comb begin
    state_n = state;
    done    = 1'b0;
    case (state)
      IDLE:    if (!rxs) state_n = START;
      START:   state_n = (vote && maj) ? IDLE : bend ? DATA : START;
      DATA:    if (bend && bc == B_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (bend) state_n = STOP;
      STOP:    if (vote && bc == S_LAST) begin
        done    = 1'b1;
        state_n = maj ? IDLE : BREAK;
      end
      BREAK:   if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1     <= 1'b1;
      rxs    <= 1'b1;
      tc     <= '0;
      bc     <= '0;
      sh     <= '0;
      smp    <= '0;
      bit_v  <= 1'b0;
      ferr_p <= 1'b0;
      perr_p <= 1'b0;
    end else begin
      s1  <= rx_data;
      rxs <= s1;
      tc  <= (state == IDLE) ? '0 : !tick ? tc : (tc == T_END) ? '0 : tc + 1'b1;
      if (tick && tc == T_LO) smp[0] <= rxs;
      if (tick && tc == T_MID) smp[1] <= rxs;
      if (vote) bit_v <= maj;
      if (state == IDLE) begin
        bc     <= '0;
        ferr_p <= 1'b0;
        perr_p <= 1'b0;
      end
      if (state == DATA && bend) begin
        sh <= {bit_v, sh[D_W-1:1]};
        bc <= (bc == B_LAST) ? '0 : bc + 1'b1;
      end
      if (state == PARITY && bend) perr_p <= bit_v ^ (^sh) ^ (PARITY_ODD != 0);
      if (state == STOP && vote) ferr_p <= ferr_p | !maj;
      // only a non-final stop bit reaches its end tick
      if (state == STOP && bend) bc <= bc + 1'b1;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      out_valid   <= load || (out_valid && !out_ready);
      overrun_err <= done && out_valid && !out_ready;
      if (load) begin
        out_data   <= sh;
        frame_err  <= ferr_p | !maj;
        parity_err <= perr_p;
      end else if (out_valid && out_ready) begin
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed and random frames into an 8N1 receiver (tick every clk)
// and an 8E2 receiver (tick every second clk), checked against expected words.
module tb_uart_rx_cfg;
  logic clk = 1'b0, rst = 1'b0, tick0 = 1'b1, tick1 = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
  logic [7:0] d0, d1;
  logic v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;
  int checks = 0, errors = 0, ov_cnt = 0, ov1_cnt = 0, v_cnt = 0;
  logic [9:0] q0[$], q1[$];

  always #5 clk = ~clk;

  uart_rx_cfg u0 (
    .clk(clk), .rst(rst), .tick(tick0), .rx_data(rx0), .out_data(d0), .out_valid(v0),
    .out_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun_err(ov0), .busy(b0)
  );

  uart_rx_cfg #(.PARITY_EN(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tick(tick1), .rx_data(rx1), .out_data(d1), .out_valid(v1),
    .out_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun_err(ov1), .busy(b1)
  );

  initial forever begin
    @(negedge clk);
    tick1 = ~tick1;
  end

  // each accepted word is recorded as {parity_err, frame_err, data}
  always @(negedge clk) begin
    if (v0 && rdy0) q0.push_back({pe0, fe0, d0});
    if (v1 && rdy1) q1.push_back({pe1, fe1, d1});
    if (ov0) ov_cnt++;
    if (ov1) ov1_cnt++;
    if (v0) v_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic [15:0] f, input int n, input int g);
    logic b;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < (w == 0 ? 16 : 32); j++) begin
        b = f[i] ^ (i == g && j == 9);
        if (w == 0) rx0 = b;
        else rx1 = b;
        @(negedge clk);
      end
  endtask

  task automatic send0(input logic [7:0] d, input int g);
    drive(0, {6'b0, 1'b1, d, 1'b0}, 10, g);
    rx0 = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send1(input logic [7:0] d, input logic pb, input logic s1, input logic s2);
    drive(1, {4'b0, s2, s1, pb, d, 1'b0}, 12, -1);
    rx1 = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_word(input int w, input logic [7:0] d, input logic f, input logic p,
                             input string tag);
    logic [9:0] e;
    int n = 0;
    while ((w == 0 ? q0.size() : q1.size()) == 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_present"}, 32'((w == 0 ? q0.size() : q1.size()) != 0), 1);
    if ((w == 0 ? q0.size() : q1.size()) != 0) begin
      if (w == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk({tag, "_word"}, e, {p, f, d});
    end
  endtask

  initial begin
    int vb, ob;
    logic [7:0] r;
    logic bad;
    repeat (3) @(negedge clk);
    chk("rst_data", d0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_ferr", fe0, 0);
    chk("rst_perr", pe1, 0);
    chk("rst_ovr", ov0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("release_idle", b0, 0);
    repeat (3) @(negedge clk);

    vb = v_cnt;
    send0(8'hA5, -1);
    expect_word(0, 8'hA5, 0, 0, "a5");
    chk("a5_valid_1clk", v_cnt - vb, 1);
    chk("a5_busy", b0, 0);

    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("fs_busy_hi", b0, 1);
    rx0 = 1'b1;
    repeat (12) @(negedge clk);
    chk("fs_busy_lo", b0, 0);
    chk("fs_no_word", q0.size(), 0);
    send0(8'h3C, -1);
    expect_word(0, 8'h3C, 0, 0, "3c");

    drive(0, {6'b0, 1'b0, 8'h55, 1'b0}, 10, -1);
    repeat (40) @(negedge clk);
    chk("brk_busy", b0, 1);
    expect_word(0, 8'h55, 1, 0, "brk");
    rx0 = 1'b1;
    repeat (4) @(negedge clk);
    chk("brk_exit", b0, 0);
    send0(8'h12, -1);
    expect_word(0, 8'h12, 0, 0, "12");

    @(posedge clk); #1 rdy0 = 1'b0;
    @(negedge clk);
    send0(8'h11, -1);
    chk("ov_valid1", v0, 1);
    chk("ov_data1", d0, 8'h11);
    ob = ov_cnt;
    send0(8'h22, -1);
    chk("ov_data2", d0, 8'h11);
    chk("ov_pulse", ov_cnt - ob, 1);
    chk("ov_valid2", v0, 1);
    @(posedge clk); #1 rdy0 = 1'b1;
    expect_word(0, 8'h11, 0, 0, "ov_acc");
    @(negedge clk);
    chk("ov_clear", v0, 0);

    @(posedge clk); #1 rdy0 = 1'b0;
    @(negedge clk);
    send0(8'h33, -1);
    chk("rs_valid_pre", v0, 1);
    drive(0, {6'b0, 1'b1, 8'hF0, 1'b0}, 5, -1);
    chk("rs_busy_pre", b0, 1);
    #2 rst = 1'b0;
    #1;
    chk("rs_valid", v0, 0);
    chk("rs_busy", b0, 0);
    chk("rs_data", d0, 0);
    rx0 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rdy0 = 1'b1;
    @(negedge clk);
    send0(8'h81, -1);
    expect_word(0, 8'h81, 0, 0, "81");

    send0(8'h5A, 3);
    expect_word(0, 8'h5A, 0, 0, "glitch_b2");
    send0(8'h5A, 8);
    expect_word(0, 8'h5A, 0, 0, "glitch_b7");

    repeat (6) begin
      r = 8'($urandom);
      send0(r, -1);
      expect_word(0, r, 0, 0, "rnd0");
    end

    send1(8'h07, 1'b1, 1'b1, 1'b1);
    expect_word(1, 8'h07, 0, 0, "par_ok");
    send1(8'h07, 1'b0, 1'b1, 1'b1);
    expect_word(1, 8'h07, 0, 1, "par_bad");
    send1(8'hC3, 1'b0, 1'b0, 1'b1);
    expect_word(1, 8'hC3, 1, 0, "stop1_low");
    chk("stop1_idle", b1, 0);

    repeat (8) begin
      r = 8'($urandom);
      bad = 1'($urandom_range(0, 1));
      send1(r, (^r) ^ bad, 1'b1, 1'b1);
      expect_word(1, r, 0, bad, "rnd1");
    end

    chk("u1_no_overrun", ov1_cnt, 0);
    chk("no_extra_words", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
